// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 8-bit memory port between the core (m0) and a second bus master (m1).
// Define MEM_ARB_RR_EN for round-robin ties and symmetric burst preemption; default is fixed m0 priority.
module mem_arbiter #(
  parameter int ADR_MSB   = 15,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m0_cs,
  input  logic             m0_we,
  input  logic [ADR_MSB:0] m0_addr,
  input  logic [7:0]       m0_odata,
  output logic [7:0]       m0_idata,
  output logic             m0_wait,
  input  logic             m1_cs,
  input  logic             m1_we,
  input  logic [ADR_MSB:0] m1_addr,
  input  logic [7:0]       m1_odata,
  output logic [7:0]       m1_idata,
  output logic             m1_wait,
  output logic             s_cs,
  output logic             s_we,
  output logic [ADR_MSB:0] s_addr,
  output logic [7:0]       s_odata,
  input  logic [7:0]       s_idata,
  input  logic             s_wait,
  output logic [1:0]       gnt
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] burst_cnt;
  logic       own0;
  logic       own1;
  logic       beat;
  logic       limit_hit;
  logic       tie_to_m1;
  logic       preempt_m0;

`ifdef MEM_ARB_RR_EN
  logic last;

  assign tie_to_m1  = ~last;
  assign preempt_m0 = 1'b1;
`else
  assign tie_to_m1  = 1'b0;
  assign preempt_m0 = 1'b0;
`endif

  assign own0      = (state == OWN0);
  assign own1      = (state == OWN1);
  assign beat      = ((own0 & m0_cs) | (own1 & m1_cs)) & ~s_wait;
  // Only a completed beat can trigger preemption, so a stalled beat is never split.
  assign limit_hit = beat && (burst_cnt >= (BURST_LIM - 4'd1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (m0_cs && m1_cs)
          state_nxt = tie_to_m1 ? OWN1 : OWN0;
        else if (m0_cs)
          state_nxt = OWN0;
        else if (m1_cs)
          state_nxt = OWN1;
      end
      OWN0: begin
        if (!m0_cs)
          state_nxt = m1_cs ? OWN1 : IDLE;
        else if (preempt_m0 && limit_hit && m1_cs)
          state_nxt = OWN1;
      end
      OWN1: begin
        if (!m1_cs)
          state_nxt = m0_cs ? OWN0 : IDLE;
        else if (limit_hit && m0_cs)
          state_nxt = OWN0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      burst_cnt <= '0;
`ifdef MEM_ARB_RR_EN
      last      <= 1'b1;
`endif
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        burst_cnt <= '0;
      else if (beat && (burst_cnt < BURST_LIM))
        burst_cnt <= burst_cnt + 4'd1;
`ifdef MEM_ARB_RR_EN
      if (state_nxt == OWN0)
        last <= 1'b0;
      else if (state_nxt == OWN1)
        last <= 1'b1;
`endif
    end
  end

  // Memory side follows the owner only; a non-owner can never reach the write strobe.
  assign gnt     = {own1, own0};
  assign s_cs    = (own0 & m0_cs) | (own1 & m1_cs);
  assign s_we    = (own0 & m0_cs & m0_we) | (own1 & m1_cs & m1_we);
  assign s_addr  = own0 ? m0_addr  : (own1 ? m1_addr  : '0);
  assign s_odata = own0 ? m0_odata : (own1 ? m1_odata : 8'h00);

  assign m0_idata = s_idata;
  assign m1_idata = s_idata;
  assign m0_wait  = m0_cs & (~own0 | s_wait);
  assign m1_wait  = m1_cs & (~own1 | s_wait);

endmodule
